// File: rtl/mc_mem_pkg.sv
// Shared types for the multicycle memory responder.
// Holds the FSM state encoding, word width and counter width.
package mc_mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    RESPOND = 2'b10
  } state_t;

  function automatic logic misaligned(
    input logic [WORD_W-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between control unit and memory.
// master: MemRead, MemWrite, Addr, WriteData out; slave: ReadData, MemReady, AddrError out.
interface multicycle_mem_responder_if;
  import mc_mem_pkg::*;

  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] Addr;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemReady;
  logic              AddrError;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, AddrError
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, AddrError
  );

endinterface

// File: rtl/mc_mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Ports: clk, we, addr (word index), wdata, rdata. Contents are never reset.
module mc_mem_array
  import mc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/multicycle_mem_responder.sv
// Multicycle memory responder: accepts one access, waits WAIT_STATES, responds.
// Ports: clk, reset (sync, active-high), bus (slave side of the request bundle).
module multicycle_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic reset,
  multicycle_mem_responder_if.slave bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              accept;
  logic              enter_resp;

  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              rd_q;
  logic              wr_q;

  logic [WORD_W-1:0] cur_addr;
  logic              cur_rd;
  logic              cur_wr;
  logic              illegal;

  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // In IDLE the live request is used so a zero-wait access can be
  // answered on the very edge that accepts it; afterwards only
  // the latched copy matters.
  assign cur_addr = (state == IDLE) ? bus.Addr     : addr_q;
  assign cur_rd   = (state == IDLE) ? bus.MemRead  : rd_q;
  assign cur_wr   = (state == IDLE) ? bus.MemWrite : wr_q;

  // Range check on the full 30-bit word index, so high
  // addresses cannot alias into the array.
  assign illegal =
    misaligned(cur_addr) ||
    ({2'b00, cur_addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS)) ||
    (cur_rd && cur_wr);

  assign mem_addr = cur_addr[AW+1:2];

  // The write lands on the edge that ends RESPOND, unless a
  // reset on that same edge aborts the access.
  assign mem_we = (state == RESPOND) && wr_q &&
                  !illegal && !reset;

  assign enter_resp = (state_nx == RESPOND) &&
                      (state != RESPOND);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(WAIT_STATES);
          end else begin
            state_nx = RESPOND;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx = RESPOND;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESPOND: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.WriteData;
        rd_q    <= bus.MemRead;
        wr_q    <= bus.MemWrite;
      end
      if (enter_resp) begin
        if (illegal)
          rdata_q <= '0;
        else if (cur_rd)
          rdata_q <= mem_rdata;
      end
    end
  end

  mc_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.ReadData  = rdata_q;
  assign bus.MemReady  = (state == RESPOND);
  assign bus.AddrError = (state == RESPOND) && illegal;

endmodule

// File: doc/multicycle_mem_responder.md
MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in storage.
REQ-002 Parameter WAIT_STATES, default 2, number of idle cycles between acceptance and response (legal range 0..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemRead  input  1  read request strobe from the control unit, held until MemReady.
REQ-006 MemWrite  input  1  write request strobe from the control unit, held until MemReady.
REQ-007 Addr  input  32  byte address of the access (IorD-selected PC or ALUOut).
REQ-008 WriteData  input  32  store data, sampled with the request.
REQ-009 ReadData  output  32  registered load/fetch data.
REQ-010 MemReady  output  1  one-cycle completion pulse for the accepted access.
REQ-011 AddrError  output  1  asserted together with MemReady when the accepted access was illegal.

Function
REQ-012 FSM SHALL have states IDLE, WAIT, RESPOND; reset state IDLE.
REQ-013 IDLE: if MemRead or MemWrite is high, the block SHALL latch Addr, WriteData and the request type on that edge. The transition SHALL be to WAIT when WAIT_STATES>0, else to RESPOND.
REQ-014 WAIT: a down-counter loaded with WAIT_STATES SHALL decrement each cycle. The transition SHALL be to RESPOND in the cycle after it reaches 1.
REQ-015 RESPOND SHALL last exactly one cycle with MemReady=1, then return to IDLE.
REQ-016 Latency: request present in cycle 0 -> MemReady high in cycle WAIT_STATES+1. The earliest next acceptance SHALL be cycle WAIT_STATES+2.
REQ-017 Inputs changing during WAIT/RESPOND SHALL be ignored; only latched values are used.
REQ-018 Read: ReadData SHALL present mem[Addr[..:2]] during the RESPOND cycle and hold it until the next completed read.
REQ-019 Write: the word SHALL commit on the edge ending RESPOND. ReadData SHALL be unchanged.
REQ-020 Read-after-write: a read accepted in the cycle after a write's RESPOND SHALL return the new data.
REQ-021 Illegal access: Addr[1:0]!=0, word index >= DEPTH_WORDS, or MemRead and MemWrite both high. Timing SHALL be unchanged and AddrError=1 in RESPOND. No write SHALL occur, and ReadData SHALL be forced to 0.
REQ-022 Word index SHALL be Addr[31:2]. Range check SHALL use the full 30 bits (no wrap-around).
REQ-023 AddrError SHALL be 0 outside RESPOND.

Reset
REQ-024 reset high at a clock edge SHALL force IDLE, MemReady=0, AddrError=0, ReadData=0 and counter=0, regardless of current state.
REQ-025 reset asserted in WAIT or RESPOND SHALL abort the access: no write commits, no MemReady pulse.
REQ-026 Storage contents SHALL NOT be altered by reset. They SHALL be zero at time 0.
REQ-027 A request present in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-028 State encoding (IDLE=2'b00, WAIT=2'b01, RESPOND=2'b10) and the word width constant SHALL live in shared package mc_mem_pkg.
REQ-029 Storage SHALL be a sub-module mc_mem_array (single-port, synchronous write, DEPTH_WORDS x 32). Control and counter SHALL remain in multicycle_mem_responder.

Verification (WAIT_STATES=2 unless stated)
REQ-030 Write Addr=0x10, data 0xDEADBEEF at cycle 0 -> MemReady=1 only in cycle 3, AddrError=0. Read 0x10 at cycle 4 -> ReadData=0xDEADBEEF in cycle 7.
REQ-031 Read Addr=0x12 -> MemReady cycle 3, AddrError=1, ReadData=0. Subsequent read of 0x10 still returns the prior value.
REQ-032 MemRead=MemWrite=1, Addr=0x20, data 0x1 -> AddrError=1. A read of 0x20 afterwards returns 0.
REQ-033 Write 0x55 to 0x40, assert reset in cycle 2 -> no MemReady. A read of 0x40 returns 0, and ReadData=0 after reset.
REQ-034 WAIT_STATES=0, back-to-back reads held continuously -> MemReady in cycles 1, 3, 5. Addr=4*DEPTH_WORDS -> AddrError=1.
REQ-035 Change Addr and WriteData during WAIT -> the originally latched address/data are used.
